// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared decode types for the core. mul_op_t is the RV32M multiply opcode
//   handed to the multiply sequencer; mul_seq_state_t is the sequencer FSM.
//   mag32() returns the 32-bit unsigned magnitude of an operand.
package decoder_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_seq_state_t;

  // The magnitude of 0x80000000 wraps back to 0x80000000, which is the
  // correct value once read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_step.sv
// mul_step
//   Combinational shift-add step: multiplies STEP multiplier bits by the
//   32-bit multiplicand, shifts the partial product by cnt*STEP and adds it
//   into the 64-bit accumulator.
// Ports
//   mplier_bits  in   STEP  low multiplier bits for this step
//   mcand        in   32    multiplicand magnitude
//   cnt          in   CW    step index
//   acc_in       in   64    current accumulator
//   acc_out      out  64    accumulator after this step
module mul_step #(
  parameter int STEP = 1,
  parameter int CW   = 5
) (
  input  logic [STEP-1:0] mplier_bits,
  input  logic [31:0]     mcand,
  input  logic [CW-1:0]   cnt,
  input  logic [63:0]     acc_in,
  output logic [63:0]     acc_out
);

  logic [5:0]  shamt;
  logic [63:0] pp;

  always_comb begin
    shamt   = 6'(cnt) * 6'(STEP);
    pp      = 64'(mplier_bits) * 64'(mcand);
    acc_out = acc_in + (pp << shamt);
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq
//   Iterative RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU). Multiplies
//   operand magnitudes STEP bits per cycle, then negates the 64-bit result
//   in a single sign-fix cycle when the true product is negative.
//   Fixed latency: accept cycle 0, RUN cycles 1..N, FIX cycle N+1,
//   rsp_valid from cycle N+2 (N = 32/STEP).
// Ports
//   clk        in   1   clock
//   reset      in   1   synchronous active-high reset
//   flush      in   1   abort any operation, discard pending result
//   req_valid  in   1   request valid
//   req_ready  out  1   high only in IDLE
//   req_op     in   2   mul_op_t
//   req_a      in   32  rs1
//   req_b      in   32  rs2
//   rsp_valid  out  1   result valid, held until rsp_ready
//   rsp_ready  in   1   consumer accepts result
//   rsp_data   out  32  low or high product word, by op
//   busy       out  1   state != IDLE
module mul_seq
  import decoder_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  mul_op_t     req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam int N  = 32 / STEP;
  localparam int CW = $clog2(N);

  if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) begin : g_bad_step
    $error("mul_seq: STEP must be 1, 2, 4 or 8");
  end

  mul_seq_state_t state;
  logic [CW-1:0]  cnt;
  mul_op_t        op_q;
  logic [31:0]    mcand;
  logic [31:0]    mplier;
  logic           neg;
  logic [63:0]    acc;
  logic [63:0]    acc_step;
  logic [63:0]    acc_fixed;
  logic           a_signed;
  logic           b_signed;
  logic           neg_in;

  mul_step #(
    .STEP (STEP),
    .CW   (CW)
  ) u_step (
    .mplier_bits (mplier[STEP-1:0]),
    .mcand       (mcand),
    .cnt         (cnt),
    .acc_in      (acc),
    .acc_out     (acc_step)
  );

  // Operand signedness and result sign come straight from the opcode.
  always_comb begin
    a_signed  = (req_op == MUL_OP_MULH) || (req_op == MUL_OP_MULHSU);
    b_signed  = (req_op == MUL_OP_MULH);
    neg_in    = (a_signed && req_a[31]) ^ (b_signed && req_b[31]);
    acc_fixed = neg ? (~acc + 64'd1) : acc;
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Reset beats flush, flush beats everything else. Accepting only in IDLE
  // means a new request can never overlap a result still waiting in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= MUL_OP_MUL;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            mcand  <= mag32(req_a, a_signed);
            mplier <= mag32(req_b, b_signed);
            neg    <= neg_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mplier <= mplier >> STEP;
          // N is a power of two, so the counter wraps to 0 on the last step.
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          acc       <= acc_fixed;
          rsp_data  <= (op_q == MUL_OP_MUL) ? acc_fixed[31:0] : acc_fixed[63:32];
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_valid_in_done : assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> (state == DONE));

  a_ready_valid_excl : assert property (@(posedge clk) disable iff (reset)
    !(req_ready && rsp_valid));

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq
//   Directed and random checks of mul_seq with STEP=1 (index 0) and STEP=4
//   (index 1). Each instance has its own handshake signals; tests run on one
//   instance at a time while the other idles.
module tb_mul_seq;
  import decoder_pkg::*;

  logic        clk;
  logic        reset     [2];
  logic        flush     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  mul_op_t     req_op    [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        busy      [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mul_seq #(
      .STEP (g == 0 ? 1 : 4)
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .flush     (flush[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_op    (req_op[g]),
      .req_a     (req_a[g]),
      .req_b     (req_b[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .busy      (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    mul_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[7];

  function automatic int stepOf(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int nOf(input int d);
    return 32 / stepOf(d);
  endfunction

  // Independent reference: sign/zero-extend to 64 bits and multiply.
  function automatic logic [31:0] refMul(input mul_op_t op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    logic [63:0] p;
    xa = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (op == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request for a single cycle; returns at the negedge of cycle 1.
  task automatic issueOp(input int d, input mul_op_t op, input logic [31:0] a,
                         input logic [31:0] b);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_a[d]     = a;
    req_b[d]     = b;
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  // Issues a request and waits (bounded) for rsp_valid; lat is the cycle,
  // counted from the accept cycle as 0, in which rsp_valid is first seen.
  task automatic applyStimulus(input int d, input mul_op_t op, input logic [31:0] a,
                               input logic [31:0] b, input string tag,
                               output logic [31:0] data, output int lat);
    issueOp(d, op, a, b);
    lat = 1;
    while (!rsp_valid[d] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[d]) begin
      checkOutput($sformatf("s%0d_%s_timeout", stepOf(d), tag), 64'(rsp_valid[d]), 64'd1);
      flush[d] = 1'b1;
      @(negedge clk);
      flush[d] = 1'b0;
    end
    data = rsp_data[d];
  endtask

  task automatic releaseRsp(input int d);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic runDut(input int d);
    logic [31:0] data;
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    mul_op_t     rop;
    int          lat;
    int          seen;
    int          nrand;
    string       s;

    s = $sformatf("s%0d", stepOf(d));

    // Directed vectors; first one also pins the exact latency.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, data, lat);
      checkOutput({s, "_", vecs[i].tag}, 64'(data), 64'(vecs[i].exp));
      if (i == 0) begin
        checkOutput({s, "_latency"}, 64'(lat), 64'(nOf(d) + 2));
      end
      releaseRsp(d);
    end

    // Backpressure: result must hold for 5 cycles, then drain on rsp_ready.
    applyStimulus(d, MUL_OP_MUL, 32'h0001_2345, 32'h0000_0010, "bp", data, lat);
    checkOutput({s, "_bp_data"}, 64'(data), 64'h0012_3450);
    held = data;
    for (int k = 0; k < 5; k++) begin
      checkOutput({s, "_bp_valid"}, 64'(rsp_valid[d]), 64'd1);
      checkOutput({s, "_bp_hold"},  64'(rsp_data[d]),  64'(held));
      checkOutput({s, "_bp_ready"}, 64'(req_ready[d]), 64'd0);
      @(negedge clk);
    end
    releaseRsp(d);
    checkOutput({s, "_bp_idle_ready"}, 64'(req_ready[d]), 64'd1);
    checkOutput({s, "_bp_idle_valid"}, 64'(rsp_valid[d]), 64'd0);

    // Flush during RUN cycle 3: back to IDLE, no response ever.
    issueOp(d, MUL_OP_MUL, 32'd9, 32'd9);
    repeat (2) @(negedge clk);
    flush[d] = 1'b1;
    @(negedge clk);
    flush[d] = 1'b0;
    checkOutput({s, "_flush_ready"}, 64'(req_ready[d]), 64'd1);
    checkOutput({s, "_flush_busy"},  64'(busy[d]),      64'd0);
    seen = 0;
    for (int k = 0; k < nOf(d) + 4; k++) begin
      if (rsp_valid[d]) seen++;
      @(negedge clk);
    end
    checkOutput({s, "_flush_no_rsp"}, 64'(seen), 64'd0);

    applyStimulus(d, MUL_OP_MUL, 32'd7, 32'd6, "after_flush", data, lat);
    checkOutput({s, "_after_flush"},     64'(data), 64'd42);
    checkOutput({s, "_after_flush_lat"}, 64'(lat),  64'(nOf(d) + 2));
    releaseRsp(d);

    // Flush together with req_valid in IDLE: nothing accepted.
    req_valid[d] = 1'b1;
    req_op[d]    = MUL_OP_MUL;
    req_a[d]     = 32'd2;
    req_b[d]     = 32'd2;
    flush[d]     = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    flush[d]     = 1'b0;
    checkOutput({s, "_flush_req_busy"},  64'(busy[d]),      64'd0);
    checkOutput({s, "_flush_req_ready"}, 64'(req_ready[d]), 64'd1);

    // Reset during FIX (cycle N+1).
    issueOp(d, MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (nOf(d)) @(negedge clk);
    checkOutput({s, "_fix_busy"}, 64'(busy[d]), 64'd1);
    reset[d] = 1'b1;
    @(negedge clk);
    reset[d] = 1'b0;
    checkOutput({s, "_rst_ready"}, 64'(req_ready[d]), 64'd1);
    checkOutput({s, "_rst_valid"}, 64'(rsp_valid[d]), 64'd0);
    checkOutput({s, "_rst_busy"},  64'(busy[d]),      64'd0);
    checkOutput({s, "_rst_data"},  64'(rsp_data[d]),  64'd0);

    // Random run against the reference model.
    nrand = (d == 0) ? 300 : 700;
    for (int k = 0; k < nrand; k++) begin
      rop = mul_op_t'($urandom_range(0, 3));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus(d, rop, ra, rb, "rand", data, lat);
      checkOutput($sformatf("%s_rand%0d_op%0d_%h_%h", s, k, rop, ra, rb),
                  64'(data), 64'(refMul(rop, ra, rb)));
      releaseRsp(d);
    end
  endtask

  initial begin
    vecs = '{
      '{MUL_OP_MUL,    32'h0000_0003, 32'h0000_0005, 32'h0000_000F, "mul_3x5"},
      '{MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1xm1"},
      '{MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minxmin"},
      '{MUL_OP_MULH,   32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "mulh_minx1"},
      '{MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff"},
      '{MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff"},
      '{MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff"}
    };

    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      flush[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_op[d]    = MUL_OP_MUL;
      req_a[d]     = '0;
      req_b[d]     = '0;
      rsp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) reset[d] = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("s%0d_reset_ready", stepOf(d)), 64'(req_ready[d]), 64'd1);
      checkOutput($sformatf("s%0d_reset_valid", stepOf(d)), 64'(rsp_valid[d]), 64'd0);
      checkOutput($sformatf("s%0d_reset_busy",  stepOf(d)), 64'(busy[d]),      64'd0);
      checkOutput($sformatf("s%0d_reset_data",  stepOf(d)), 64'(rsp_data[d]),  64'd0);
    end

    for (int d = 0; d < 2; d++) begin
      $display("[TB] running STEP=%0d", stepOf(d));
      runDut(d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
